// File: rtl/mem_pkg.sv
// Shared types for the data memory unit and its load-alignment helper.
//   mem_size_e  : access size encoding (byte/half/word/double)
//   state_e     : request FSM states
//   size_bytes(): number of bytes touched by an access of a given size
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10,
    MEM_D = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic [3:0] size_bytes(input mem_size_e size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load data formatter: takes 8 raw bytes (byte 0 = lowest
// address), keeps the bytes of the requested size and sign- or zero-extends.
//   raw    in  64      bytes in little-endian order
//   size   in  2       access size
//   unsign in  1       1 zero-extend, 0 sign-extend (ignored for doubles)
//   data   out DATA_W  extended load value
module mem_load_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [63:0]       raw,
  input  mem_size_e         size,
  input  logic              unsign,
  output logic [DATA_W-1:0] data
);

  logic [63:0] ext;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned; an unassigned path would infer a latch.
  always_comb begin
    ext = raw;
    unique case (size)
      MEM_B:   ext = {{56{~unsign & raw[7]}},  raw[7:0]};
      MEM_H:   ext = {{48{~unsign & raw[15]}}, raw[15:0]};
      MEM_W:   ext = {{32{~unsign & raw[31]}}, raw[31:0]};
      default: ext = raw;
    endcase
  end

  assign data = ext[DATA_W-1:0];

endmodule

// File: rtl/data_mem_unit.sv
// Byte-addressable data memory with valid/ready request and response
// handshakes, fixed read latency, extended loads and alignment/range faults.
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (one outstanding request)
//   req_we                1 store, 0 load
//   req_size              00 byte, 01 half, 10 word, 11 double
//   req_unsign            loads: 1 zero-extend, 0 sign-extend
//   req_addr, req_wdata   byte address, store data (LSBs used per size)
//   resp_valid/resp_ready response handshake (stores respond too)
//   resp_rdata            extended load data, 0 for stores and faults
//   resp_err              misaligned (when ALIGN_CHK) or out-of-range access
module data_mem_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 8192,
  parameter int LATENCY   = 1,
  parameter int ALIGN_CHK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W     = $clog2(DEPTH);
  localparam int WAIT_LAST = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam int CNT_W     = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  logic [7:0] mem [0:DEPTH-1];

  state_e           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             ready_q;

  // Request decode
  mem_size_e   size_in;
  logic        accept;
  logic [3:0]  nbytes;
  logic        misalign;
  logic [ADDR_W:0] end_addr;
  logic        fault;
  logic [63:0] wdata64;
  logic [63:0] raw_live;

  assign size_in  = mem_size_e'(req_size);
  assign accept   = req_valid & ready_q;
  assign nbytes   = size_bytes(size_in);
  assign wdata64  = 64'(req_wdata);
  // One extra bit so addresses near the top of the space cannot wrap past DEPTH.
  assign end_addr = {1'b0, req_addr} + (ADDR_W+1)'(nbytes);

  always_comb begin
    misalign = 1'b0;
    case (size_in)
      MEM_H:   misalign = req_addr[0];
      MEM_W:   misalign = |req_addr[1:0];
      MEM_D:   misalign = |req_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end

  assign fault = (end_addr > (ADDR_W+1)'(DEPTH)) | (misalign & (ALIGN_CHK != 0));

  // Raw bytes at addr..addr+7; bytes beyond the access size are dropped by
  // the aligner, so wrapping the index past the top is harmless.
  always_comb begin
    raw_live = '0;
    for (int i = 0; i < 8; i++) begin
      raw_live[8*i +: 8] = mem[req_addr[IDX_W-1:0] + IDX_W'(i)];
    end
  end

  // NOTE: the byte array has no reset; only control and response state does.
  always_ff @(posedge clk) begin
    if (accept && req_we && !fault) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < nbytes) begin
          mem[req_addr[IDX_W-1:0] + IDX_W'(i)] <= wdata64[8*i +: 8];
        end
      end
    end
  end

  // Request captured at acceptance, consumed when the FSM enters RESP.
  logic [63:0] pend_raw;
  mem_size_e   pend_size;
  logic        pend_unsign, pend_zero, pend_err;

  // With LATENCY=1 RESP is entered on the acceptance edge itself, so the
  // live request feeds the response path directly.
  logic [63:0]       src_raw;
  mem_size_e         src_size;
  logic              src_unsign, src_zero, src_err;
  logic [DATA_W-1:0] load_data;

  assign src_raw    = accept ? raw_live            : pend_raw;
  assign src_size   = accept ? size_in             : pend_size;
  assign src_unsign = accept ? req_unsign          : pend_unsign;
  assign src_zero   = accept ? (req_we | fault)    : pend_zero;
  assign src_err    = accept ? fault               : pend_err;

  mem_load_align #(.DATA_W(DATA_W)) u_align (
    .raw    (src_raw),
    .size   (src_size),
    .unsign (src_unsign),
    .data   (load_data)
  );

  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_d      = '0;
          next_state = (LATENCY > 1) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_W'(WAIT_LAST)) next_state = ST_RESP;
        else                          cnt_d      = cnt + CNT_W'(1);
      end
      ST_RESP: begin
        if (resp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ready_q     <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      pend_raw    <= '0;
      pend_size   <= MEM_B;
      pend_unsign <= 1'b0;
      pend_zero   <= 1'b0;
      pend_err    <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= cnt_d;
      // Registered ready: no combinational path from req_valid.
      ready_q <= (next_state == ST_IDLE);
      if (accept) begin
        pend_raw    <= raw_live;
        pend_size   <= size_in;
        pend_unsign <= req_unsign;
        pend_zero   <= req_we | fault;
        pend_err    <= fault;
      end
      if (next_state == ST_RESP && state != ST_RESP) begin
        resp_rdata <= src_zero ? '0 : load_data;
        resp_err   <= src_err;
      end
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = (state == ST_RESP);

endmodule
